wt_store_wbuf: RTL and testbench

- Write buffer that sits between the store unit and the memory request port of the write-through data cache.
- Holds up to DEPTH word-aligned store entries and merges byte writes to the same word.
- Drains entries in order to the memory interface and caps in-flight writes at MAX_OUTSTANDING.
- Gives the load unit a read-after-write hazard check against buffered words.
- Defaults match the 32-bit core: DEPTH 2, MAX_OUTSTANDING 7.

---
 rtl/wt_store_wbuf_if.sv | 48 ++++
 rtl/wt_store_wbuf.sv | 170 +++++++++++++++++
 tb/tb_wt_store_wbuf.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_store_wbuf_if.sv
// wt_store_wbuf_if
// Purpose: bundles the store-request, memory-write, load-hazard and status
//          signals of the write-through store write buffer.
// Signals:
//   req_valid_i/req_ready_o/req_addr_i/req_data_i/req_be_i : store request
//   mem_valid_o/mem_ready_i/mem_addr_o/mem_data_o/mem_be_o : memory write port
//   mem_ack_i                                               : one write completed
//   load_addr_i/load_hit_o                                  : load hazard check
//   outstanding_o/empty_o                                   : drain status
// Modports: slave = the write buffer, master = store unit / memory side.
interface wt_store_wbuf_if #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 7
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic [BE_W-1:0]   req_be_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_ack_i;
  logic [ADDR_W-1:0] load_addr_i;
  logic              load_hit_o;
  logic [CNT_W-1:0]  outstanding_o;
  logic              empty_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i,
    input  mem_ready_i, mem_ack_i, load_addr_i,
    output req_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o,
    output load_hit_o, outstanding_o, empty_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_be_i,
    output mem_ready_i, mem_ack_i, load_addr_i,
    input  req_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o,
    input  load_hit_o, outstanding_o, empty_o
  );
endinterface

// File: rtl/wt_store_wbuf.sv
// wt_store_wbuf
// Purpose: store write buffer for the write-through data cache. Buffers up to
//          DEPTH word-aligned stores, drains them in order to memory, limits
//          issued-but-unacknowledged writes to MAX_OUTSTANDING and flags loads
//          that hit a buffered word.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : wt_store_wbuf_if.slave (store request, memory write, ack,
//           load hazard check, outstanding count, empty flag)
// Build option: define WT_STORE_WBUF_MERGE_EN to merge a store into the
//   youngest entry when it targets the same word; without it every accepted
//   store allocates its own entry.
module wt_store_wbuf #(
  parameter int DEPTH           = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wt_store_wbuf_if.slave   bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WA_W   = ADDR_W - OFF_W;

  // Entries keep only the word part of the address.
  logic [WA_W-1:0]   addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [BE_W-1:0]   be_r   [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  valid_nxt_s;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [FILL_W-1:0] count_r;
  logic [FILL_W-1:0] count_nxt_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  outstanding_nxt_s;
  logic [WA_W-1:0]   req_word_s;
  logic [WA_W-1:0]   load_word_s;
  logic              merge_s;
  logic              push_s;
  logic              pop_s;
  logic              ack_s;
  logic              hit_s;
  logic              unused_s;

  assign req_word_s  = bus.req_addr_i[ADDR_W-1:OFF_W];
  assign load_word_s = bus.load_addr_i[ADDR_W-1:OFF_W];
  // Byte offsets inside the word play no part in matching or issuing.
  assign unused_s    = ^{bus.req_addr_i[OFF_W-1:0], bus.load_addr_i[OFF_W-1:0]};

`ifdef WT_STORE_WBUF_MERGE_EN
  logic [PTR_W-1:0] youngest_s;
  assign youngest_s = tail_r - PTR_W'(1);
  // With two or more entries the youngest is never the head, so it can be
  // rewritten without disturbing a pending memory handshake.
  assign merge_s = bus.req_valid_i && (count_r >= FILL_W'(2)) &&
                   (req_word_s == addr_r[youngest_s]);
`else
  assign merge_s = 1'b0;
`endif

  // A full buffer refuses pushes even while it pops in the same cycle.
  assign bus.req_ready_o = (count_r < FILL_W'(DEPTH)) | merge_s;
  assign bus.mem_valid_o = (count_r != {FILL_W{1'b0}}) &&
                           (outstanding_r < CNT_W'(MAX_OUTSTANDING));
  assign push_s = bus.req_valid_i & bus.req_ready_o & ~merge_s;
  assign pop_s  = bus.mem_valid_o & bus.mem_ready_i;
  assign ack_s  = bus.mem_ack_i & (outstanding_r != {CNT_W{1'b0}});

  assign bus.mem_addr_o    = {addr_r[head_r], {OFF_W{1'b0}}};
  assign bus.mem_data_o    = data_r[head_r];
  assign bus.mem_be_o      = be_r[head_r];
  assign bus.outstanding_o = outstanding_r;
  assign bus.empty_o       = (count_r == {FILL_W{1'b0}}) &&
                             (outstanding_r == {CNT_W{1'b0}});
  assign bus.load_hit_o    = hit_s;

  // Load hazard: any valid entry holding the load's word, head included.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_r[i] & (addr_r[i] == load_word_s));
    end
  end

  // Entry valid bits: clear the popped head, set the pushed tail.
  always_comb begin
    valid_nxt_s = valid_r;
    if (pop_s) begin
      valid_nxt_s[head_r] = 1'b0;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
    if (push_s) begin
      valid_nxt_s[tail_r] = 1'b1;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Fill level and in-flight write count.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + FILL_W'(1);
      2'b01:   count_nxt_s = count_r - FILL_W'(1);
      default: count_nxt_s = count_r;
    endcase
    outstanding_nxt_s = outstanding_r;
    case ({pop_s, ack_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_W'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Entry storage: allocate at tail, or merge bytes into the youngest entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {WA_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
        be_r[i]   <= {BE_W{1'b0}};
      end
      valid_r <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        addr_r[tail_r] <= req_word_s;
        data_r[tail_r] <= bus.req_data_i;
        be_r[tail_r]   <= bus.req_be_i;
      end
`ifdef WT_STORE_WBUF_MERGE_EN
      if (merge_s) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.req_be_i[b]) begin
            data_r[youngest_s][8*b +: 8] <= bus.req_data_i[8*b +: 8];
          end
        end
        be_r[youngest_s] <= be_r[youngest_s] | bus.req_be_i;
      end
`endif
      valid_r <= valid_nxt_s;
    end
  end

  // Pointers, fill level and outstanding counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {FILL_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      count_r       <= count_nxt_s;
      outstanding_r <= outstanding_nxt_s;
    end
  end
endmodule

// File: tb/tb_wt_store_wbuf.sv
// tb_wt_store_wbuf
// Purpose: directed self-checking bench for wt_store_wbuf (default parameters).
//          Inputs change 1 ns after the rising edge; outputs are sampled
//          between edges.
module tb_wt_store_wbuf;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 7;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  wt_store_wbuf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)) bus ();

  wt_store_wbuf #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_data_i  = 32'h0;
    bus.req_be_i    = 4'h0;
    bus.mem_ready_i = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.load_addr_i = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    bus.req_be_i    = be;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h1000;
    bus.req_data_i  = 32'hAABBCCDD;
    bus.req_be_i    = 4'hF;
    bus.load_addr_i = 32'h1000;
    #1;
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", bus.empty_o); end
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready_o); end
    n_cmp++; if (bus.load_hit_o !== 1'b0) begin n_err++; $display("FAIL rst_load_hit got=%b exp=0", bus.load_hit_o); end
    n_cmp++; if (bus.outstanding_o !== 3'd0) begin n_err++; $display("FAIL rst_outstanding got=%0d exp=0", bus.outstanding_o); end
    n_cmp++; if ({bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o} !== 68'h0) begin n_err++; $display("FAIL rst_mem_bus got=%h/%h/%h exp=0", bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o); end
    tick();
    rst = 1'b0;
    #1;
    // request is presented but not yet taken: nothing visible, incoming word not a hit
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL first_pre_valid got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.load_hit_o !== 1'b0) begin n_err++; $display("FAIL first_pre_hit got=%b exp=0", bus.load_hit_o); end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_valid_o !== 1'b1) begin n_err++; $display("FAIL first_valid got=%b exp=1", bus.mem_valid_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h1000) begin n_err++; $display("FAIL first_addr got=%h exp=00001000", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 32'hAABBCCDD) begin n_err++; $display("FAIL first_data got=%h exp=aabbccdd", bus.mem_data_o); end
    n_cmp++; if (bus.mem_be_o !== 4'hF) begin n_err++; $display("FAIL first_be got=%h exp=f", bus.mem_be_o); end
    n_cmp++; if (bus.empty_o !== 1'b0) begin n_err++; $display("FAIL first_empty got=%b exp=0", bus.empty_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.outstanding_o !== 3'd1) begin n_err++; $display("FAIL first_outst got=%0d exp=1", bus.outstanding_o); end
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL first_drained got=%b exp=1", bus.empty_o); end
  endtask

  task automatic test_merge();
    do_reset();
    push(32'h2000, 32'h00000011, 4'h1);
    push(32'h2004, 32'h33445566, 4'hF);
    bus.req_addr_i  = 32'h2004;
    bus.req_data_i  = 32'h00002200;
    bus.req_be_i    = 4'h2;
    bus.req_valid_i = 1'b1;
    #1;
`ifdef WT_STORE_WBUF_MERGE_EN
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL merge_ready got=%b exp=1", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_addr_o !== 32'h2000) begin n_err++; $display("FAIL merge_head got=%h exp=00002000", bus.mem_addr_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_addr_o !== 32'h2004) begin n_err++; $display("FAIL merge_addr got=%h exp=00002004", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 32'h33442266) begin n_err++; $display("FAIL merge_data got=%h exp=33442266", bus.mem_data_o); end
    n_cmp++; if (bus.mem_be_o !== 4'hF) begin n_err++; $display("FAIL merge_be got=%h exp=f", bus.mem_be_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL merge_no_third got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.outstanding_o !== 3'd2) begin n_err++; $display("FAIL merge_outst got=%0d exp=2", bus.outstanding_o); end
`else
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL nomerge_stall got=%b exp=0", bus.req_ready_o); end
    tick();
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL nomerge_stall2 got=%b exp=0", bus.req_ready_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h2000) begin n_err++; $display("FAIL nomerge_head got=%h exp=00002000", bus.mem_addr_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL nomerge_ready got=%b exp=1", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_data_o !== 32'h33445566) begin n_err++; $display("FAIL nomerge_data1 got=%h exp=33445566", bus.mem_data_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_addr_o !== 32'h2004) begin n_err++; $display("FAIL nomerge_addr2 got=%h exp=00002004", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 32'h00002200) begin n_err++; $display("FAIL nomerge_data2 got=%h exp=00002200", bus.mem_data_o); end
    n_cmp++; if (bus.mem_be_o !== 4'h2) begin n_err++; $display("FAIL nomerge_be2 got=%h exp=2", bus.mem_be_o); end
`endif
  endtask

  task automatic test_full_pop();
    do_reset();
    push(32'h4000, 32'hA0A0A0A0, 4'hF);
    push(32'h4010, 32'hB0B0B0B0, 4'hF);
    bus.req_addr_i  = 32'h4020;
    bus.req_data_i  = 32'hC0C0C0C0;
    bus.req_be_i    = 4'hF;
    bus.req_valid_i = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL full_refuse got=%b exp=0", bus.req_ready_o); end
    n_cmp++; if (bus.mem_valid_o !== 1'b1) begin n_err++; $display("FAIL full_mem_valid got=%b exp=1", bus.mem_valid_o); end
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready_next got=%b exp=1", bus.req_ready_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h4010) begin n_err++; $display("FAIL full_head got=%h exp=00004010", bus.mem_addr_o); end
    n_cmp++; if (bus.outstanding_o !== 3'd1) begin n_err++; $display("FAIL full_outst got=%0d exp=1", bus.outstanding_o); end
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL full_again got=%b exp=0", bus.req_ready_o); end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_addr_o !== 32'h4020) begin n_err++; $display("FAIL full_late_addr got=%h exp=00004020", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 32'hC0C0C0C0) begin n_err++; $display("FAIL full_late_data got=%h exp=c0c0c0c0", bus.mem_data_o); end
  endtask

  task automatic test_outstanding();
    int w;
    do_reset();
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.req_addr_i  = 32'h5000 + 32'(i * 4);
      bus.req_data_i  = 32'(i);
      bus.req_be_i    = 4'hF;
      bus.req_valid_i = 1'b1;
      #1;
      w = 0;
      while (bus.req_ready_o !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      n_cmp++; if (w >= 20) begin n_err++; $display("FAIL outst_accept_%0d got=timeout exp=accepted", i); end
      tick();
    end
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.outstanding_o !== 3'd7) begin n_err++; $display("FAIL outst_sat got=%0d exp=7", bus.outstanding_o); end
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL outst_valid_drop got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h501C) begin n_err++; $display("FAIL outst_head got=%h exp=0000501c", bus.mem_addr_o); end
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL outst_full got=%b exp=0", bus.req_ready_o); end
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    n_cmp++; if (bus.outstanding_o !== 3'd6) begin n_err++; $display("FAIL outst_ack got=%0d exp=6", bus.outstanding_o); end
    n_cmp++; if (bus.mem_valid_o !== 1'b1) begin n_err++; $display("FAIL outst_reissue got=%b exp=1", bus.mem_valid_o); end
    tick();
    n_cmp++; if (bus.outstanding_o !== 3'd7) begin n_err++; $display("FAIL outst_one_more got=%0d exp=7", bus.outstanding_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h5020) begin n_err++; $display("FAIL outst_last_head got=%h exp=00005020", bus.mem_addr_o); end
    tick();
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL outst_only_one got=%b exp=0", bus.mem_valid_o); end
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_ack_same();
    do_reset();
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'h6000 + 32'(i * 16), 32'(i), 4'hF);
      tick();
    end
    bus.mem_ready_i = 1'b0;
    push(32'h6030, 32'h3, 4'hF);
    n_cmp++; if (bus.outstanding_o !== 3'd3) begin n_err++; $display("FAIL ack_pre got=%0d exp=3", bus.outstanding_o); end
    bus.mem_ready_i = 1'b1;
    bus.mem_ack_i   = 1'b1;
    #1;
    n_cmp++; if (bus.mem_valid_o !== 1'b1) begin n_err++; $display("FAIL ack_hs_valid got=%b exp=1", bus.mem_valid_o); end
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_ack_i   = 1'b0;
    #1;
    n_cmp++; if (bus.outstanding_o !== 3'd3) begin n_err++; $display("FAIL ack_same got=%0d exp=3", bus.outstanding_o); end
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL ack_drained got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.empty_o !== 1'b0) begin n_err++; $display("FAIL ack_not_empty got=%b exp=0", bus.empty_o); end
    bus.mem_ack_i = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (bus.outstanding_o !== 3'd0) begin n_err++; $display("FAIL ack_down got=%0d exp=0", bus.outstanding_o); end
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    n_cmp++; if (bus.outstanding_o !== 3'd0) begin n_err++; $display("FAIL ack_at_zero got=%0d exp=0", bus.outstanding_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL ack_empty got=%b exp=1", bus.empty_o); end
  endtask

  task automatic test_load_hit();
    do_reset();
    push(32'h3008, 32'h12345678, 4'hF);
    bus.load_addr_i = 32'h300B;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b1) begin n_err++; $display("FAIL hit_300b got=%b exp=1", bus.load_hit_o); end
    bus.load_addr_i = 32'h300C;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b0) begin n_err++; $display("FAIL hit_300c got=%b exp=0", bus.load_hit_o); end
    bus.load_addr_i = 32'h3004;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b0) begin n_err++; $display("FAIL hit_3004 got=%b exp=0", bus.load_hit_o); end
    push(32'h3010, 32'h9ABCDEF0, 4'hF);
    bus.mem_ready_i = 1'b1;
    bus.load_addr_i = 32'h3008;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b1) begin n_err++; $display("FAIL hit_head_hs got=%b exp=1", bus.load_hit_o); end
    tick();
    bus.load_addr_i = 32'h3010;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b1) begin n_err++; $display("FAIL hit_mid_drain got=%b exp=1", bus.load_hit_o); end
    n_cmp++; if (bus.outstanding_o !== 3'd1) begin n_err++; $display("FAIL hit_outst got=%0d exp=1", bus.outstanding_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.load_hit_o !== 1'b0) begin n_err++; $display("FAIL midrst_hit got=%b exp=0", bus.load_hit_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL midrst_empty got=%b exp=1", bus.empty_o); end
    n_cmp++; if (bus.mem_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", bus.mem_valid_o); end
    n_cmp++; if (bus.outstanding_o !== 3'd0) begin n_err++; $display("FAIL midrst_outst got=%0d exp=0", bus.outstanding_o); end
    tick();
    rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_ack_i   = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    n_cmp++; if (bus.outstanding_o !== 3'd0) begin n_err++; $display("FAIL late_ack got=%0d exp=0", bus.outstanding_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL late_ack_empty got=%b exp=1", bus.empty_o); end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_full_pop();
    test_outstanding();
    test_ack_same();
    test_load_hit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
